// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer with one-entry IR; FETCH_PERF_CNT_EN adds instr_cnt
module fetch_seq #(
    parameter logic [7:0] P0_BASE  = 8'd0,
    parameter logic [7:0] P1_BASE  = 8'd66,
    parameter logic [7:0] P2_BASE  = 8'd121,
    parameter logic [7:0] P3_BASE  = 8'd130,
    parameter logic [7:0] HALT_OPC = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    output logic [7:0]  imem_addr,
    input  logic [7:0]  imem_data,
    input  logic        redirect,
    input  logic [7:0]  redirect_target,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [7:0]  ir_data,
    output logic [7:0]  ir_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] instr_cnt,
`endif
    output logic        busy,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] base;
    logic       handshake;
    logic       slot_free;

    always_comb begin
        base = P0_BASE;
        case (prog_sel)
            2'd0: base = P0_BASE;
            2'd1: base = P1_BASE;
            2'd2: base = P2_BASE;
            2'd3: base = P3_BASE;
            default: base = P0_BASE;
        endcase
    end

    assign imem_addr = pc;
    assign handshake = ir_valid && ir_ready;
    assign slot_free = !ir_valid || ir_ready;

`ifdef FETCH_PERF_CNT_EN
    // Counts consumed entries only; a flushed entry never reaches this path.
    logic count_hs;
    assign count_hs = handshake && !start && !(state == FETCH && redirect);

    always_ff @(posedge clk) begin
        if (rst || start)
            instr_cnt <= 16'h0000;
        else if (count_hs && instr_cnt != 16'hFFFF)
            instr_cnt <= instr_cnt + 16'h0001;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= 8'h00;
            ir_valid <= 1'b0;
            ir_data  <= 8'h00;
            ir_pc    <= 8'h00;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else if (start) begin
            state    <= FETCH;
            pc       <= base;
            ir_valid <= 1'b0;
            busy     <= 1'b1;
            halted   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc       <= redirect_target;
                        ir_valid <= 1'b0;
                    end else if (slot_free) begin
                        if (imem_data == HALT_OPC) begin
                            ir_valid <= 1'b0;
                            state    <= HALT;
                            busy     <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            ir_data  <= imem_data;
                            ir_pc    <= pc;
                            ir_valid <= 1'b1;
                            pc       <= pc + 8'd1;
                        end
                    end
                end
                default: begin
                    if (handshake)
                        ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst, start, redirect, ir_ready;
    logic [1:0]  prog_sel;
    logic [7:0]  redirect_target, imem_addr, imem_data, ir_data, ir_pc;
    logic        ir_valid, busy, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] instr_cnt;
`endif

    logic [7:0] rom [256];
    assign imem_data = rom[imem_addr];

    fetch_seq dut (
        .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_target(redirect_target),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
`ifdef FETCH_PERF_CNT_EN
        .instr_cnt(instr_cnt),
`endif
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start;
        logic [1:0] sel;
        logic       redir;
        logic [7:0] tgt;
        logic       rdy;
        logic       ev;
        logic [7:0] epc, edata, eaddr;
        logic       ebusy, ehalt;
    } vec_t;

    vec_t vt[12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic found, saw_ff;
        logic [7:0] last_pc, last_data;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[165] = 8'h00;
        rom[0] = 8'hD4; rom[1] = 8'h50; rom[2] = 8'h51;
        rom[96] = 8'h42; rom[124] = 8'hFF;
        rom[142] = 8'h50; rom[143] = 8'hFF;

        rst = 1'b0; start = 1'b0; prog_sel = 2'd0;
        redirect = 1'b0; redirect_target = 8'd0; ir_ready = 1'b0;

        // rst, start, sel, redir, tgt, rdy, ev, epc, edata, eaddr, ebusy, ehalt
        vt[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'h00, 8'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 8'h00, 8'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 8'hD4, 8'd1, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 8'h50, 8'd2, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 8'h51, 8'd3, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 8'h59, 8'd4, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 8'h5E, 8'd5, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 8'h5F, 8'd6, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 8'h5F, 8'd6, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 8'h5F, 8'd6, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 8'h5F, 8'd6, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd6, 8'h5C, 8'd7, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; start = vt[i].start; prog_sel = vt[i].sel;
            redirect = vt[i].redir; redirect_target = vt[i].tgt; ir_ready = vt[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), 16'(ir_valid), 16'(vt[i].ev));
            chk($sformatf("vec%0d_addr", i), 16'(imem_addr), 16'(vt[i].eaddr));
            chk($sformatf("vec%0d_busy", i), 16'(busy), 16'(vt[i].ebusy));
            chk($sformatf("vec%0d_halted", i), 16'(halted), 16'(vt[i].ehalt));
            if (vt[i].ev || vt[i].rst) begin
                chk($sformatf("vec%0d_ir_pc", i), 16'(ir_pc), 16'(vt[i].epc));
                chk($sformatf("vec%0d_ir_data", i), 16'(ir_data), 16'(vt[i].edata));
            end
        end
        rst = 1'b0; start = 1'b0; ir_ready = 1'b1;

        // branch flush in program 1
        start = 1'b1; prog_sel = 2'd1; step(); start = 1'b0;
        chk("flush_start_addr", 16'(imem_addr), 16'd66);
        found = 1'b0; n = 0;
        while (!found && n < 60) begin
            step(); n++;
            if (ir_valid && ir_pc == 8'd104) found = 1'b1;
        end
        chk("flush_reach_104", 16'(found), 16'd1);
        redirect = 1'b1; redirect_target = 8'd96; step(); redirect = 1'b0;
        chk("flush_valid_cleared", 16'(ir_valid), 16'd0);
        chk("flush_addr", 16'(imem_addr), 16'd96);
        step();
        chk("flush_tgt_valid", 16'(ir_valid), 16'd1);
        chk("flush_tgt_pc", 16'(ir_pc), 16'd96);
        chk("flush_tgt_data", 16'(ir_data), 16'h42);

        // halt in program 3
        start = 1'b1; prog_sel = 2'd3; step(); start = 1'b0;
        n = 0; saw_ff = 1'b0; last_pc = 8'd0; last_data = 8'd0;
        while (!halted && n < 40) begin
            step(); n++;
            if (ir_valid) begin
                last_pc = ir_pc; last_data = ir_data;
                if (ir_data == 8'hFF) saw_ff = 1'b1;
            end
        end
        chk("halt_reached", 16'(halted), 16'd1);
        chk("halt_last_pc", 16'(last_pc), 16'd142);
        chk("halt_last_data", 16'(last_data), 16'h50);
        chk("halt_no_ff", 16'(saw_ff), 16'd0);
        chk("halt_busy", 16'(busy), 16'd0);
        chk("halt_valid", 16'(ir_valid), 16'd0);
        redirect = 1'b1; redirect_target = 8'd5; step(); redirect = 1'b0;
        chk("halt_redir_ignored", 16'(halted), 16'd1);
        chk("halt_pc_held", 16'(imem_addr), 16'd143);
        start = 1'b1; prog_sel = 2'd0; step(); start = 1'b0;
        chk("restart_busy", 16'(busy), 16'd1);
        chk("restart_halted", 16'(halted), 16'd0);
        chk("restart_addr", 16'(imem_addr), 16'd0);

        // pc wrap then reset mid-stream (with start to show rst wins)
        redirect = 1'b1; redirect_target = 8'hFF; step(); redirect = 1'b0;
        chk("wrap_redir_addr", 16'(imem_addr), 16'hFF);
        step();
        chk("wrap_pc_ff", 16'(ir_pc), 16'hFF);
        chk("wrap_data_ff", 16'(ir_data), 16'hA5);
        chk("wrap_addr_0", 16'(imem_addr), 16'd0);
        step();
        chk("wrap_pc_0", 16'(ir_pc), 16'd0);
        chk("wrap_data_0", 16'(ir_data), 16'hD4);
        rst = 1'b1; start = 1'b1; prog_sel = 2'd2; step(); rst = 1'b0; start = 1'b0;
        chk("rst_valid", 16'(ir_valid), 16'd0);
        chk("rst_addr", 16'(imem_addr), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ir_pc", 16'(ir_pc), 16'd0);
        chk("rst_ir_data", 16'(ir_data), 16'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_cnt", instr_cnt, 16'd0);
`endif
        redirect = 1'b1; redirect_target = 8'd50; step(); redirect = 1'b0;
        chk("idle_redir_addr", 16'(imem_addr), 16'd0);
        chk("idle_redir_busy", 16'(busy), 16'd0);

        // program 2: halt opcode waiting behind a stalled entry
        start = 1'b1; prog_sel = 2'd2; step(); start = 1'b0;
        found = 1'b0; n = 0;
        while (!found && n < 10) begin
            step(); n++;
            if (ir_valid && ir_pc == 8'd123) found = 1'b1;
        end
        chk("p2_reach_123", 16'(found), 16'd1);
        ir_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stall_valid", 16'(ir_valid), 16'd1);
            chk("stall_pc", 16'(ir_pc), 16'd123);
            chk("stall_not_halted", 16'(halted), 16'd0);
        end
        ir_ready = 1'b1; step();
        chk("p2_halted", 16'(halted), 16'd1);
        chk("p2_valid", 16'(ir_valid), 16'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_at_halt", instr_cnt, 16'd3);
`endif
        start = 1'b1; step(); start = 1'b0;
        chk("p2_restart_busy", 16'(busy), 16'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_after_start", instr_cnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
